word_narrower: RTL
==================

Name: word_narrower

Overview:
- Converts a 32-bit word into 16-bit halfword beats over a valid/ready stream.
- This is the narrowing counterpart of the 16-to-32 zero extender.
- Used to move register or ALU words across 16-bit paths such as the immediate/halfword bus and debug ports.
- When the upper half is all zero (the word is a zero-extended halfword) and compression is enabled, one beat is sent instead of two.
- Keeps wrap-around counts of words and beats for debug.

Parameters:
- COMPRESS, 1: 1 means a word whose bits 31:16 are zero is sent as a single beat; 0 means every word is sent as two beats.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  the block accepts a word this cycle.
- in_data  input  32  word to narrow.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  the downstream block accepts the beat.
- out_data  output  16  current halfword beat.
- out_last  output  1  the current beat is the final beat of its word.
- out_zext  output  1  bits 31:16 of the current word are zero; constant across all beats of that word.
- word_cnt  output  CNT_W  count of completed words, wraps.
- short_cnt  output  CNT_W  count of words sent as a single beat, wraps.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low (rst_n), and its polarity and synchronicity are fixed.
- Reset values: state IDLE, word register 0, out_valid 0, out_data 0, out_last 0, out_zext 0, word_cnt 0, short_cnt 0, in_ready 1.
- State machine: IDLE, LOW, HIGH, with 2-bit encoding from the shared package.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - When in_valid = 1: latch in_data into the word register, latch zflag = (in_data[31:16] == 0), and go to LOW.
  - Latency: the first beat is presented in the cycle after acceptance.
- LOW:
  - in_ready = 0, out_valid = 1, out_data = word[15:0], out_zext = zflag.
  - out_last = COMPRESS & zflag.
  - On out_ready = 1 with out_last = 1: go to IDLE, increment word_cnt, increment short_cnt.
  - On out_ready = 1 with out_last = 0: go to HIGH.
- HIGH:
  - in_ready = 0, out_valid = 1, out_data = word[31:16], out_last = 1, out_zext = zflag.
  - On out_ready = 1: go to IDLE and increment word_cnt.
- Stall: while out_valid = 1 and out_ready = 0, out_data, out_last and out_zext hold stable and the state does not change.
- Output timing:
  - in_ready is decoded only from state, with no combinational path from in_valid or out_ready.
  - out_* are driven from registers or a state-selected mux of registers, with no combinational path from inputs.
- Throughput: a 2-beat word takes 3 cycles (accept, LOW, HIGH). A compressed word takes 2 cycles. in_ready is deasserted in LOW and HIGH by design.
- Counters: wrap from all-ones to 0 with no saturation and no sticky flag.
- Boundary cases:
  - in_data = 0x00000000 with COMPRESS = 1 gives a single beat 0x0000 with last = 1 and zext = 1.
  - in_data = 0x0000FFFF with COMPRESS = 1 gives a single beat.
  - in_data = 0x00010000 gives two beats.
  - With COMPRESS = 0, out_zext still reports the flag but out_last is 1 only in HIGH.
  - in_valid while in LOW or HIGH is ignored because in_ready = 0. The upstream block must hold the word.
  - Reset mid-word drops the word immediately: out_valid goes to 0 asynchronously, the state returns to IDLE and the counters clear.
  - Inputs are X-safe while in_valid = 0: nothing is latched.

Decomposition:
- Shared package holds:
  - the state encoding constants ST_IDLE = 2'd0, ST_LOW = 2'd1, ST_HIGH = 2'd2;
  - the halfword width constant HW = 16.
- One natural sub-module, wrap_counter: a CNT_W-bit counter with enable and asynchronous active-low clear. It is instantiated twice, for word_cnt and short_cnt.
- The upper-half zero detect is a 16-input NOR, built inline.

Test Plan:
- Reset then idle: hold rst_n = 0 for 3 cycles, then release. Required: in_ready = 1, out_valid = 0, both counters 0.
- Full word, COMPRESS = 1, out_ready held at 1: drive in_data = 0x12345678. Required:
  - cycle +1: out_data = 0x5678, last = 0, zext = 0;
  - cycle +2: out_data = 0x1234, last = 1;
  - afterwards: word_cnt = 1, short_cnt = 0.
- Compressed word, COMPRESS = 1: drive in_data = 0x0000ABCD. Required:
  - one beat 0xABCD with last = 1 and zext = 1;
  - the block returns to IDLE the next cycle;
  - word_cnt = 1, short_cnt = 1.
- Backpressure: drive in_data = 0xDEAD0001 and hold out_ready = 0 for 4 cycles in LOW. Required:
  - out_data stays 0x0001, last stays 0, in_ready stays 0 throughout;
  - after out_ready is released, the beats are 0x0001 then 0xDEAD.
- COMPRESS = 0 instance: drive in_data = 0x0000FFFF. Required: two beats 0xFFFF then 0x0000, zext = 1 on both, last = 1 only on the second, short_cnt stays 0.
- Reset mid-word: accept 0xCAFEBABE, then pull rst_n low in HIGH. Required:
  - out_valid drops at once;
  - after release, state is IDLE and word_cnt = 0;
  - the next word 0x00000005 yields a single beat 0x0005.

Source files
------------

// File: rtl/word_narrower_pkg.sv
// Shared types and constants for the 32-to-16 word narrower.
// State encoding and halfword width used by the RTL slice.
package word_narrower_pkg;

    localparam int HW = 16;
    localparam int WW = 2 * HW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

endpackage

// File: rtl/word_narrower_if.sv
// Word-in / halfword-out valid/ready stream bundle.
// slave is the narrower side, master is the producer/consumer side.
interface word_narrower_if;
    import word_narrower_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [HW-1:0] out_data;
    logic          out_last;
    logic          out_zext;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_zext
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_zext
    );

endinterface

// File: rtl/word_narrower_wrap_counter.sv
// Free-running wrap-around event counter.
// Cleared asynchronously, steps by one when enabled.
module wrap_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    // count enabled events, wrapping from all-ones to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/word_narrower.sv
// Narrows 32-bit words into one or two 16-bit beats.
// Zero-extended halfwords collapse to one beat when COMPRESS is set.
module word_narrower
    import word_narrower_pkg::*;
#(
    parameter bit COMPRESS = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    word_narrower_if.slave   bus,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] short_cnt
);

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] word;
    logic          zflag;
    logic          zero_hi;
    logic          accept;

    logic          in_ready;
    logic          out_valid;
    logic [HW-1:0] out_data;
    logic          out_last;
    logic          out_zext;
    logic          word_done;
    logic          short_done;

    assign zero_hi = ~|bus.in_data[WW-1:HW];
    assign accept  = (state == ST_IDLE) & bus.in_valid;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // capture the word and its upper-half-zero flag on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word  <= '0;
            zflag <= 1'b0;
        end else if (accept) begin
            word  <= bus.in_data;
            zflag <= zero_hi;
        end
    end

    // next state and state-decoded outputs
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        out_zext   = 1'b0;
        word_done  = 1'b0;
        short_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                out_valid = 1'b1;
                out_data  = word[HW-1:0];
                out_last  = COMPRESS & zflag;
                out_zext  = zflag;
                if (bus.out_ready) begin
                    if (out_last) begin
                        state_nxt  = ST_IDLE;
                        word_done  = 1'b1;
                        short_done = 1'b1;
                    end else begin
                        state_nxt = ST_HIGH;
                    end
                end
            end
            ST_HIGH: begin
                out_valid = 1'b1;
                out_data  = word[WW-1:HW];
                out_last  = 1'b1;
                out_zext  = zflag;
                if (bus.out_ready) begin
                    state_nxt = ST_IDLE;
                    word_done = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.out_zext  = out_zext;

    wrap_counter #(.W(CNT_W)) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (word_done),
        .count (word_cnt)
    );

    wrap_counter #(.W(CNT_W)) u_short_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (short_done),
        .count (short_cnt)
    );

endmodule
